// File: rtl/sprite_layer_arbiter_pkg.sv
// Shared constants for the sprite layer and the object address generators.
//   SPR_ADDR_W      - sprite-sheet ROM address width
//   SPR_PIX_W       - RGB444 pixel width
//   SHEET_W         - sprite sheet width in pixels
//   SPR_TRANSPARENT - ROM colour that is keyed out
// RGB444 field helpers extract the colour channels of a pixel.
package sprite_layer_arbiter_pkg;

  localparam int SPR_ADDR_W = 17;
  localparam int SPR_PIX_W  = 12;
  localparam int SHEET_W    = 320;
  localparam logic [SPR_PIX_W-1:0] SPR_TRANSPARENT = 12'h0F0;

  function automatic logic [3:0] rgb_r(input logic [SPR_PIX_W-1:0] pix);
    return pix[11:8];
  endfunction

  function automatic logic [3:0] rgb_g(input logic [SPR_PIX_W-1:0] pix);
    return pix[7:4];
  endfunction

  function automatic logic [3:0] rgb_b(input logic [SPR_PIX_W-1:0] pix);
    return pix[3:0];
  endfunction

endpackage

// File: rtl/sprite_layer_arbiter_prio_enc.sv
// Combinational fixed-priority encoder; the lowest set request index wins.
//   req - request vector
//   any - at least one request is set
//   idx - index of the winning request (0 when any=0)
module prio_enc #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  // Scan from the top down so the lowest set index is the last write.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        any = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/sprite_layer_arbiter.sv
// Shares the sprite-sheet ROM port between NUM_OBJ object address
// generators, one pixel per clock, three-stage pipeline:
//   S1: pick winner, register rom_addr and side-band
//   S2: ROM registers its data, side-band delayed
//   S3: key out transparent colour or override the background
// Ports:
//   clk, rst_n           - pixel clock, async active-low reset
//   obj_en, obj_addr     - per-object "inside sprite" flags and addresses
//   mask_in, frame_start - visibility mask, latched on frame_start
//   valid_in, bg_pixel_in- active-video flag and background colour
//   rom_addr, rom_data   - registered ROM address, ROM data one cycle later
//   pixel_out, valid_out, hit_out, hit_idx - final pixel and its source
//   collision_frame      - overlap seen during the previous frame
module sprite_layer_arbiter
  import sprite_layer_arbiter_pkg::*;
#(
  parameter int NUM_OBJ = 4,
  parameter int ADDR_W  = SPR_ADDR_W,
  parameter int PIX_W   = SPR_PIX_W,
  parameter logic [PIX_W-1:0] TRANSPARENT = SPR_TRANSPARENT,
  localparam int IDX_W  = $clog2(NUM_OBJ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_OBJ-1:0]        obj_en,
  input  logic [NUM_OBJ*ADDR_W-1:0] obj_addr,
  input  logic [NUM_OBJ-1:0]        mask_in,
  input  logic                      frame_start,
  input  logic                      valid_in,
  input  logic [PIX_W-1:0]          bg_pixel_in,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [PIX_W-1:0]          rom_data,
  output logic [PIX_W-1:0]          pixel_out,
  output logic                      valid_out,
  output logic                      hit_out,
  output logic [IDX_W-1:0]          hit_idx,
  output logic                      collision_frame
);

  localparam int CNT_W = $clog2(NUM_OBJ) + 1;

  logic [NUM_OBJ-1:0] req;
  logic               sel_any;
  logic [IDX_W-1:0]   sel_idx;
  logic [CNT_W-1:0]   req_cnt;
  logic               collision_now;

  logic [ADDR_W-1:0]  rom_addr_d, rom_addr_q;
  logic               s1_hit_d, s1_hit_q, s2_hit_q;
  logic [IDX_W-1:0]   s1_idx_d, s1_idx_q, s2_idx_q;
  logic               s1_valid_q, s2_valid_q;
  logic [PIX_W-1:0]   s1_bg_q, s2_bg_q;
  logic [PIX_W-1:0]   pixel_d, pixel_q;
  logic               hit_d, hit_q;
  logic [IDX_W-1:0]   hit_idx_d, hit_idx_q;
  logic               valid_out_q;
  logic [NUM_OBJ-1:0] active_mask_d, active_mask_q;
  logic               sticky_d, sticky_q;
  logic               coll_frame_d, coll_frame_q;

  // The mask in use is the latched one, so a pixel in the frame_start
  // cycle still sees the previous frame's mask.
  assign req = obj_en & active_mask_q & {NUM_OBJ{valid_in}};

  prio_enc #(.N(NUM_OBJ), .IDX_W(IDX_W)) u_prio_enc (
    .req (req),
    .any (sel_any),
    .idx (sel_idx)
  );

  always_comb begin
    req_cnt = '0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      req_cnt = req_cnt + CNT_W'(req[i]);
    end
  end

  assign collision_now = (req_cnt >= CNT_W'(2));

  always_comb begin
    rom_addr_d    = '0;
    s1_hit_d      = sel_any;
    s1_idx_d      = sel_idx;
    pixel_d       = '0;
    hit_d         = 1'b0;
    hit_idx_d     = '0;
    active_mask_d = active_mask_q;
    sticky_d      = sticky_q | collision_now;
    coll_frame_d  = coll_frame_q;

    if (sel_any) begin
      rom_addr_d = obj_addr[sel_idx*ADDR_W +: ADDR_W];
    end

    // A transparent winner shows the background; lower-priority objects
    // are deliberately not consulted.
    if (s2_valid_q) begin
      if (s2_hit_q && (rom_data != TRANSPARENT)) begin
        pixel_d   = rom_data;
        hit_d     = 1'b1;
        hit_idx_d = s2_idx_q;
      end else begin
        pixel_d = s2_bg_q;
      end
    end

    // A collision in the frame_start cycle belongs to the ending frame.
    if (frame_start) begin
      active_mask_d = mask_in;
      coll_frame_d  = sticky_q | collision_now;
      sticky_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr_q    <= '0;
      s1_hit_q      <= 1'b0;
      s1_idx_q      <= '0;
      s1_valid_q    <= 1'b0;
      s1_bg_q       <= '0;
      s2_hit_q      <= 1'b0;
      s2_idx_q      <= '0;
      s2_valid_q    <= 1'b0;
      s2_bg_q       <= '0;
      pixel_q       <= '0;
      hit_q         <= 1'b0;
      hit_idx_q     <= '0;
      valid_out_q   <= 1'b0;
      active_mask_q <= '1;
      sticky_q      <= 1'b0;
      coll_frame_q  <= 1'b0;
    end else begin
      rom_addr_q    <= rom_addr_d;
      s1_hit_q      <= s1_hit_d;
      s1_idx_q      <= s1_idx_d;
      s1_valid_q    <= valid_in;
      s1_bg_q       <= bg_pixel_in;
      s2_hit_q      <= s1_hit_q;
      s2_idx_q      <= s1_idx_q;
      s2_valid_q    <= s1_valid_q;
      s2_bg_q       <= s1_bg_q;
      pixel_q       <= pixel_d;
      hit_q         <= hit_d;
      hit_idx_q     <= hit_idx_d;
      valid_out_q   <= s2_valid_q;
      active_mask_q <= active_mask_d;
      sticky_q      <= sticky_d;
      coll_frame_q  <= coll_frame_d;
    end
  end

  assign rom_addr        = rom_addr_q;
  assign pixel_out       = pixel_q;
  assign hit_out         = hit_q;
  assign hit_idx         = hit_idx_q;
  assign valid_out       = valid_out_q;
  assign collision_frame = coll_frame_q;

endmodule

// File: tb/tb_sprite_layer_arbiter.sv
module tb_sprite_layer_arbiter;

  localparam logic [11:0] TRANSP = 12'h0F0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  obj_en = '0;
  logic [67:0] obj_addr;
  logic [3:0]  mask_in = '0;
  logic        frame_start = 1'b0;
  logic        valid_in = 1'b0;
  logic [11:0] bg_pixel_in = '0;
  logic [16:0] rom_addr;
  logic [11:0] rom_data = '0;
  logic [11:0] pixel_out;
  logic        valid_out;
  logic        hit_out;
  logic [1:0]  hit_idx;
  logic        collision_frame;

  logic [16:0] a [4];
  assign obj_addr = {a[3], a[2], a[1], a[0]};

  sprite_layer_arbiter dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .obj_en          (obj_en),
    .obj_addr        (obj_addr),
    .mask_in         (mask_in),
    .frame_start     (frame_start),
    .valid_in        (valid_in),
    .bg_pixel_in     (bg_pixel_in),
    .rom_addr        (rom_addr),
    .rom_data        (rom_data),
    .pixel_out       (pixel_out),
    .valid_out       (valid_out),
    .hit_out         (hit_out),
    .hit_idx         (hit_idx),
    .collision_frame (collision_frame)
  );

  always #5 clk = ~clk;

  // Sprite sheet contents: one known word, a family of transparent
  // addresses, everything else opaque.
  function automatic logic [11:0] rom_word(input logic [16:0] addr);
    if (addr == 17'd341) return 12'hABC;
    if (addr[2:0] == 3'b101) return TRANSP;
    return addr[11:0] ^ 12'h5A5;
  endfunction

  always @(posedge clk) rom_data <= rom_word(rom_addr);

  typedef struct packed {
    logic [11:0] pix;
    logic        hit;
    logic [1:0]  idx;
    logic        vld;
  } exp_t;

  exp_t exp_q[$];
  logic [3:0]  m_mask;
  logic        m_sticky;
  logic        m_cf;
  logic [16:0] m_addr;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, want, $time);
  endtask

  task automatic model_reset();
    m_mask   = 4'b1111;
    m_sticky = 1'b0;
    m_cf     = 1'b0;
    exp_q.delete();
    exp_q.push_back('0);
    exp_q.push_back('0);
  endtask

  // Present the current inputs for one pixel, predict, and check the
  // outputs that become visible after this clock.
  task automatic step();
    logic [3:0] req;
    int         cnt;
    int         win;
    exp_t       e;
    req = obj_en & m_mask & {4{valid_in}};
    cnt = $countones(req);
    win = -1;
    for (int i = 0; i < 4; i++) if (req[i] && win < 0) win = i;
    m_addr = (win >= 0) ? a[win] : 17'd0;
    e = '0;
    if (valid_in) begin
      e.vld = 1'b1;
      if (win >= 0 && rom_word(a[win]) != TRANSP) begin
        e.pix = rom_word(a[win]);
        e.hit = 1'b1;
        e.idx = 2'(win);
      end else begin
        e.pix = bg_pixel_in;
      end
    end
    if (frame_start) begin
      m_cf     = m_sticky | (cnt >= 2);
      m_sticky = 1'b0;
      m_mask   = mask_in;
    end else if (cnt >= 2) begin
      m_sticky = 1'b1;
    end
    exp_q.push_back(e);
    @(negedge clk);
    chk("rom_addr", 32'(rom_addr), 32'(m_addr));
    chk("collision_frame", 32'(collision_frame), 32'(m_cf));
    e = exp_q.pop_front();
    chk("pixel_out", 32'(pixel_out), 32'(e.pix));
    chk("hit_out", 32'(hit_out), 32'(e.hit));
    chk("hit_idx", 32'(hit_idx), 32'(e.idx));
    chk("valid_out", 32'(valid_out), 32'(e.vld));
  endtask

  task automatic do_reset();
    valid_in    = 1'b0;
    frame_start = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("rst rom_addr", 32'(rom_addr), 0);
    chk("rst pixel_out", 32'(pixel_out), 0);
    chk("rst valid_out", 32'(valid_out), 0);
    chk("rst hit_out", 32'(hit_out), 0);
    chk("rst hit_idx", 32'(hit_idx), 0);
    chk("rst collision_frame", 32'(collision_frame), 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_idle();
    obj_en = '0; frame_start = 1'b0; valid_in = 1'b0; bg_pixel_in = '0;
    for (int i = 0; i < 4; i++) a[i] = '0;
  endtask

  initial begin
    set_idle();
    mask_in = 4'b1111;
    @(negedge clk);
    do_reset();

    // Single object with the known ROM word.
    obj_en = 4'b0010; a[1] = 17'd341; valid_in = 1'b1; bg_pixel_in = 12'h777;
    step();
    set_idle(); step(); step();

    // Overlap: objects 1 and 2 both opaque, then frame_start reports it.
    obj_en = 4'b0110; a[1] = 17'd16; a[2] = 17'd32; valid_in = 1'b1;
    step();
    set_idle(); step(); step();
    frame_start = 1'b1; mask_in = 4'b1111; step();
    set_idle(); step();

    // Transparent winner shows background, no fallthrough.
    obj_en = 4'b0011; a[0] = 17'd5; a[1] = 17'd64; valid_in = 1'b1; bg_pixel_in = 12'h123;
    step();
    set_idle(); step(); step();

    // Mask change mid-frame ignored until frame_start.
    obj_en = 4'b0001; a[0] = 17'd8; valid_in = 1'b1; mask_in = 4'b1110;
    step(); step();
    frame_start = 1'b1; step();
    frame_start = 1'b0; step(); step();
    set_idle(); step(); step();

    // Blanking: no output, no collision.
    frame_start = 1'b1; step();
    obj_en = 4'b1111; frame_start = 1'b0; step();
    set_idle(); step(); frame_start = 1'b1; step();
    set_idle(); step(); step();

    // Reset mid-stream restores mask to all ones.
    obj_en = 4'b0001; valid_in = 1'b1; a[0] = 17'd40;
    step();
    do_reset();
    obj_en = 4'b0001; valid_in = 1'b1; a[0] = 17'd40;
    step();
    set_idle(); step(); step();

    // Randomized traffic with occasional frame starts and resets.
    for (int n = 0; n < 500; n++) begin
      obj_en      = 4'($urandom);
      mask_in     = 4'($urandom);
      valid_in    = ($urandom_range(0, 9) < 8);
      frame_start = ($urandom_range(0, 24) == 0);
      bg_pixel_in = 12'($urandom);
      for (int i = 0; i < 4; i++) begin
        case ($urandom_range(0, 3))
          0: a[i] = 17'd341;
          1: a[i] = {14'($urandom), 3'b101};
          default: a[i] = 17'($urandom);
        endcase
      end
      step();
      if (n == 170 || n == 340) do_reset();
    end

    set_idle(); step(); step(); step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
